// File: rtl/dmem_arbiter_if.sv
// Shared-memory bus: two requester ports, a tagged response and the memory side.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p1_gnt,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p1_gnt,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and IDLE/ACCESS/RESP sequencer in front of
// the single-port DataMemory; one access per three cycles.
module dmem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = MEM_DEPTH[ADDR_W:0];

    state_t            r_state;
    state_t            w_next;

    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_id;
    logic              r_err;

    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_id;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_take;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_win_we;
    logic              w_win_err;

    // Tie goes to the port that did not win last time.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE && !rst) begin
            unique case ({bus.p1_req, bus.p0_req})
                2'b01: w_gnt0 = 1'b1;
                2'b10: w_gnt1 = 1'b1;
                2'b11: begin
                    if (r_last) w_gnt0 = 1'b1;
                    else        w_gnt1 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_take      = w_gnt0 | w_gnt1;
    assign w_win_addr  = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
    assign w_win_wdata = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;
    assign w_win_we    = w_gnt1 ? bus.p1_we    : bus.p0_we;
    assign w_win_err   = ({1'b0, w_win_addr} >= LP_DEPTH);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_take) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_id    <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE && w_take) begin
            r_last  <= w_gnt1;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_we    <= w_win_we;
            r_id    <= w_gnt1;
            r_err   <= w_win_err;
        end
    end

    // Response fields hold until the next access overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_rsp_rdata <= (r_we | r_err) ? '0 : bus.mem_rdata;
            r_rsp_err   <= r_err;
            r_rsp_id    <= r_id;
        end
    end

    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Address/data stay latched so the level-sensitive write sees stable values.
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = (r_state == ACCESS) & r_we & ~r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a DataMemory model (word i = i).
// Inputs change 1ns after the rising edge; outputs sampled 1ns later.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i;
    end

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 16'd256)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = (bus.mem_addr < 16'd256) ? mem[bus.mem_addr[7:0]] : 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
    endtask

    // One complete transaction from a single port, starting in IDLE.
    task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input bit exp_err);
        if (port) begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
        end else begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
        end
        #1;
        chk("gnt0", {31'd0, bus.p0_gnt}, {31'd0, ~port});
        chk("gnt1", {31'd0, bus.p1_gnt}, {31'd0, port});
        chk("we_idle", {31'd0, bus.mem_we}, 32'd0);
        step();
        clr_req();
        #1;
        chk("acc_addr", {16'd0, bus.mem_addr}, {16'd0, addr});
        chk("acc_we", {31'd0, bus.mem_we}, {31'd0, we & ~exp_err});
        chk("acc_valid", {31'd0, bus.rsp_valid}, 32'd0);
        if (we && !exp_err) chk("acc_wdata", bus.mem_wdata, wd);
        step();
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, port});
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk("rsp_we", {31'd0, bus.mem_we}, 32'd0);
        step();
        chk("post_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_hold", bus.rsp_rdata, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ep;
        bit eg;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;

        #3;
        chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
        step();
        rst = 1'b0;

        txn(1'b0, 1'b0, 16'h0005, 32'd0, 32'd5, 1'b0);

        txn(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'd0, 1'b0);
        txn(1'b1, 1'b0, 16'h0010, 32'd0, 32'hDEADBEEF, 1'b0);

        // Both ports hold req: grants every 3 cycles, alternating 0,1,0,1.
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 16'h0001;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 16'h0002;
        for (int c = 0; c < 12; c++) begin
            #1;
            ep = ((c / 3) % 2) == 1;
            eg = (c % 3) == 0;
            chk("rr_gnt0", {31'd0, bus.p0_gnt}, {31'd0, eg & ~ep});
            chk("rr_gnt1", {31'd0, bus.p1_gnt}, {31'd0, eg & ep});
            chk("rr_valid", {31'd0, bus.rsp_valid}, {31'd0, (c % 3) == 2});
            if (c % 3 == 2) begin
                chk("rr_id", {31'd0, bus.rsp_id}, {31'd0, ep});
                chk("rr_rdata", bus.rsp_rdata, ep ? 32'd2 : 32'd1);
            end
            step();
        end
        clr_req();

        txn(1'b0, 1'b1, 16'h0100, 32'h12345678, 32'd0, 1'b1);
        txn(1'b0, 1'b0, 16'h00FF, 32'd0, 32'h000000FF, 1'b0);

        // Reset in the middle of a write's ACCESS cycle.
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 16'h0020; bus.p0_wdata = 32'hCAFE0000;
        #1;
        chk("rw_gnt0", {31'd0, bus.p0_gnt}, 32'd1);
        step();
        clr_req();
        #1;
        chk("rw_we_on", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_we_off", {31'd0, bus.mem_we}, 32'd0);
        chk("rw_valid0", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        chk("rw_valid1", {31'd0, bus.rsp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rw_valid2", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        chk("rw_valid3", {31'd0, bus.rsp_valid}, 32'd0);
        txn(1'b1, 1'b0, 16'h0021, 32'd0, 32'h00000021, 1'b0);

        // p1 arrives during p0's ACCESS; waits for IDLE.
        bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 16'h0003;
        #1;
        chk("late_gnt0", {31'd0, bus.p0_gnt}, 32'd1);
        step();
        bus.p0_req = 0;
        bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 16'h0007;
        #1;
        chk("late_acc_gnt1", {31'd0, bus.p1_gnt}, 32'd0);
        step();
        chk("late_rsp_gnt1", {31'd0, bus.p1_gnt}, 32'd0);
        chk("late_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("late_rsp_rdata", bus.rsp_rdata, 32'd3);
        step();
        chk("late_idle_gnt1", {31'd0, bus.p1_gnt}, 32'd1);
        step();
        bus.p1_req = 0;
        step();
        chk("late_p1_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("late_p1_id", {31'd0, bus.rsp_id}, 32'd1);
        chk("late_p1_rdata", bus.rsp_rdata, 32'd7);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
